// File: rtl/rvv_backend_alu_rs.sv
// ALU reservation station: a DEPTH-entry circular FIFO with up to two in-order dispatch
// writes and one issue read per cycle. A sticky flag records any dispatch that was refused.
module rvv_backend_alu_rs #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_flush,
  input  logic             push0,
  input  logic             push1,
  input  logic [UOP_W-1:0] uop0,
  input  logic [UOP_W-1:0] uop1,
  output logic             alu_uop_valid,
  output logic [UOP_W-1:0] alu_uop,
  input  logic             pop_rs,
  output logic             fifo_full,
  output logic             fifo_almost_full,
  output logic             fifo_empty,
  output logic             overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] free;
  logic [PTR_W-1:0] wr_ptr_nx1;
  logic [PTR_W-1:0] wr_ptr_nx2;
  logic [PTR_W-1:0] rd_ptr_nx1;
  logic             pop_ok;
  logic             acc_one;
  logic             acc_two;
  logic             push_err;
  logic [CNT_W-1:0] n_push;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_C) return '0;
    else             return p + PTR_W'(1);
  endfunction

  always_comb begin
    free       = DEPTH_C - count;
    wr_ptr_nx1 = ptr_inc(wr_ptr);
    wr_ptr_nx2 = ptr_inc(wr_ptr_nx1);
    rd_ptr_nx1 = ptr_inc(rd_ptr);
    pop_ok     = pop_rs && (count != '0);
    // Space is judged on the registered count; a same-cycle pop never frees a slot.
    acc_one    = push0 && !push1 && (free >= CNT_W'(1));
    acc_two    = push0 && push1 && (free >= CNT_W'(2));
    push_err   = (push0 || push1) && !acc_one && !acc_two;
    n_push     = '0;
    if (acc_one) n_push = CNT_W'(1);
    if (acc_two) n_push = CNT_W'(2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (trap_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc_one) wr_ptr <= wr_ptr_nx1;
      if (acc_two) wr_ptr <= wr_ptr_nx2;
      if (pop_ok)  rd_ptr <= rd_ptr_nx1;
      count <= count + n_push - CNT_W'(pop_ok);
      if (push_err) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !trap_flush) begin
      if (acc_one || acc_two) mem[wr_ptr]     <= uop0;
      if (acc_two)            mem[wr_ptr_nx1] <= uop1;
    end
  end

  assign alu_uop_valid    = (count != '0);
  assign alu_uop          = mem[rd_ptr];
  assign fifo_empty       = (count == '0);
  assign fifo_almost_full = (count >= DEPTH_C - CNT_W'(1));
  assign fifo_full        = (count == DEPTH_C);

endmodule

// File: tb/tb_rvv_backend_alu_rs.sv
// Directed bench for rvv_backend_alu_rs: an 8-deep instance for ordering, overflow,
// flush and reset cases, and a 5-deep instance for pointer wrap-around.
module tb_rvv_backend_alu_rs;

  localparam int W = 32;

  logic         clk = 1'b0;
  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  // 8-deep instance
  logic         rst_a, flush_a, push0_a, push1_a, pop_a;
  logic [W-1:0] uop0_a, uop1_a, uop_a;
  logic         valid_a, full_a, afull_a, empty_a, ovf_a;

  // 5-deep instance
  logic         rst_b, flush_b, push0_b, push1_b, pop_b;
  logic [W-1:0] uop0_b, uop1_b, uop_b;
  logic         valid_b, full_b, afull_b, empty_b, ovf_b;

  rvv_backend_alu_rs #(.DEPTH(8), .UOP_W(W)) dut_a (
    .clk(clk), .rst(rst_a), .trap_flush(flush_a),
    .push0(push0_a), .push1(push1_a), .uop0(uop0_a), .uop1(uop1_a),
    .alu_uop_valid(valid_a), .alu_uop(uop_a), .pop_rs(pop_a),
    .fifo_full(full_a), .fifo_almost_full(afull_a), .fifo_empty(empty_a),
    .overflow_err(ovf_a)
  );

  rvv_backend_alu_rs #(.DEPTH(5), .UOP_W(W)) dut_b (
    .clk(clk), .rst(rst_b), .trap_flush(flush_b),
    .push0(push0_b), .push1(push1_b), .uop0(uop0_b), .uop1(uop1_b),
    .alu_uop_valid(valid_b), .alu_uop(uop_b), .pop_rs(pop_b),
    .fifo_full(full_b), .fifo_almost_full(afull_b), .fifo_empty(empty_b),
    .overflow_err(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    push0_a = 0; push1_a = 0; pop_a = 0; flush_a = 0; rst_a = 0;
  endtask

  task automatic push_a(input logic [W-1:0] a, input logic [W-1:0] b, input bit two);
    push0_a = 1; push1_a = two; uop0_a = a; uop1_a = b;
    step();
    idle_a();
  endtask

  logic [W-1:0] q[$];
  int unsigned  remaining;
  int unsigned  next_val;
  int unsigned  n_pops;

  initial begin
    idle_a();
    uop0_a = '0; uop1_a = '0;
    rst_b = 1; flush_b = 0; push0_b = 0; push1_b = 0; pop_b = 0;
    uop0_b = '0; uop1_b = '0;
    rst_a = 1;
    #1;
    step();
    step();
    rst_a = 0; rst_b = 0;

    check("rst_valid", valid_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_full",  full_a,  0);
    check("rst_afull", afull_a, 0);
    check("rst_ovf",   ovf_a,   0);

    // Dual push then two pops
    push_a(32'hA, 32'hB, 1);
    check("dual_valid", valid_a, 1);
    check("dual_head",  uop_a,   32'hA);
    pop_a = 1; step();
    check("pop1_head",  uop_a,   32'hB);
    check("pop1_valid", valid_a, 1);
    step();
    check("pop2_empty", empty_a, 1);
    check("pop2_valid", valid_a, 0);
    // Pop on empty is ignored
    step();
    pop_a = 0;
    check("pop_empty_empty", empty_a, 1);
    check("pop_empty_ovf",   ovf_a,   0);

    // push1 without push0
    push1_a = 1; uop1_a = 32'hDEAD; step(); idle_a();
    check("p1only_ovf",   ovf_a,   1);
    check("p1only_empty", empty_a, 1);
    rst_a = 1; step(); idle_a();
    check("rst_clr_ovf", ovf_a, 0);

    // Fill to 7 with values 10..16
    push_a(32'd10, 32'd11, 1);
    push_a(32'd12, 32'd13, 1);
    push_a(32'd14, 32'd15, 1);
    push_a(32'd16, 32'd0, 0);
    check("c7_afull", afull_a, 1);
    check("c7_full",  full_a,  0);
    check("c7_ovf",   ovf_a,   0);
    push_a(32'h77, 32'h78, 1);
    check("c7_dual_afull", afull_a, 1);
    check("c7_dual_full",  full_a,  0);
    check("c7_dual_ovf",   ovf_a,   1);
    push_a(32'd17, 32'd0, 0);
    check("c8_full", full_a, 1);
    // Full with pop + push: push refused, count drops to 7
    push0_a = 1; uop0_a = 32'h99; pop_a = 1; step(); idle_a();
    check("c8pp_full",  full_a,  0);
    check("c8pp_afull", afull_a, 1);
    check("c8pp_ovf",   ovf_a,   1);
    for (int unsigned i = 11; i <= 17; i++) begin
      check("drain_head", uop_a, 64'(i));
      pop_a = 1; step(); idle_a();
    end
    check("drain_empty", empty_a, 1);

    // Pop on a one-entry buffer with a push in the same cycle
    push_a(32'h20, 32'h0, 0);
    push0_a = 1; uop0_a = 32'h21; pop_a = 1; step(); idle_a();
    check("pp1_head",  uop_a,   32'h21);
    check("pp1_valid", valid_a, 1);
    pop_a = 1; step(); idle_a();
    check("pp1_empty", empty_a, 1);

    // Flush beats push and pop; sticky error survives it
    push_a(32'h30, 32'h31, 1);
    push_a(32'h32, 32'h33, 1);
    push_a(32'h34, 32'h0, 0);
    flush_a = 1; push0_a = 1; uop0_a = 32'h3F; pop_a = 1; step(); idle_a();
    check("flush_empty", empty_a, 1);
    check("flush_valid", valid_a, 0);
    check("flush_ovf",   ovf_a,   1);
    push_a(32'h55, 32'h0, 0);
    check("post_flush_head", uop_a, 32'h55);

    // Reset mid-operation at count 3 with a push active
    push_a(32'h56, 32'h57, 1);
    rst_a = 1; push0_a = 1; uop0_a = 32'h58; step(); idle_a();
    check("midrst_empty", empty_a, 1);
    check("midrst_ovf",   ovf_a,   0);
    check("midrst_valid", valid_a, 0);
    step();
    check("midrst_hold_empty", empty_a, 1);

    // 5-deep wrap: 20 values through with interleaved pops
    remaining = 20; next_val = 32'h100; n_pops = 0;
    for (int unsigned cyc = 0; cyc < 100 && (remaining > 0 || q.size() > 0); cyc++) begin
      push0_b = 0; push1_b = 0; pop_b = 0;
      if (q.size() >= 2 || (remaining == 0 && q.size() > 0)) begin
        check("wrap_valid", valid_b, 1);
        check("wrap_head",  uop_b,   64'(q.pop_front()));
        pop_b = 1;
        n_pops++;
      end
      if (remaining >= 2 && (cyc % 3 == 0) && q.size() <= 1) begin
        push0_b = 1; push1_b = 1;
        uop0_b = W'(next_val); uop1_b = W'(next_val + 1);
        q.push_back(W'(next_val)); q.push_back(W'(next_val + 1));
        next_val += 2; remaining -= 2;
      end else if (remaining > 0) begin
        push0_b = 1; uop0_b = W'(next_val);
        q.push_back(W'(next_val));
        next_val++; remaining--;
      end
      step();
    end
    push0_b = 0; push1_b = 0; pop_b = 0;
    check("wrap_pops",  64'(n_pops), 20);
    check("wrap_empty", empty_b, 1);
    check("wrap_ovf",   ovf_b,   0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvv_backend_alu_rs.md
RVV_BACKEND_ALU_RS -- requirements
Module: rvv_backend_alu_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of ALU_RS_t entries held (legal range 2..16).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have trap_flush  input  1  discards all entries.
REQ-005 SHALL have push0 / push1  input  1 each  dispatch write requests, in program order (push1 is younger).
REQ-006 SHALL have uop0 / uop1  input  ALU_RS_t each  dispatch payloads for push0 / push1.
REQ-007 SHALL have alu_uop_valid  output  1  head entry present.
REQ-008 SHALL have alu_uop  output  ALU_RS_t  head entry payload.
REQ-009 SHALL have pop_rs  input  1  ALU consumed the head this cycle.
REQ-010 SHALL have fifo_full, fifo_almost_full, fifo_empty  output  1 each  occupancy status.
REQ-011 SHALL have overflow_err  output  1  sticky protocol-violation flag.

Function
REQ-012 SHALL store entries in a circular buffer with wr_ptr, rd_ptr (clog2(DEPTH) bits) and count (clog2(DEPTH+1) bits).
REQ-013 SHALL wrap each pointer from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-014 SHALL drive alu_uop_valid = (count != 0) and alu_uop = entry[rd_ptr]; both come from registers only, with no combinational path from push or pop inputs.
REQ-015 SHALL set fifo_empty = (count==0), fifo_almost_full = (count >= DEPTH-1), and fifo_full = (count==DEPTH).
REQ-016 SHALL accept a pop only when pop_rs=1 and count!=0, advancing rd_ptr by 1.
REQ-017 SHALL ignore pop_rs when empty, with no state change.
REQ-018 SHALL base push acceptance on registered count only; free slots are DEPTH-count, and a same-cycle pop does not create space.
REQ-019 SHALL accept push0 alone when free>=1.
REQ-020 SHALL accept push0+push1 only when free>=2; uop0 is written at wr_ptr and uop1 at wr_ptr+1 (wrapped), and wr_ptr advances by 2.
REQ-021 SHALL reject a request atomically when there is insufficient space (both uops dropped, no partial write) and set overflow_err.
REQ-022 SHALL treat push1 without push0 as a violation: nothing is written and overflow_err is set.
REQ-023 SHALL update count next = count + accepted_pushes - accepted_pop when push and pop occur in the same cycle; a pop on a one-entry buffer with a push to the same cycle is legal.
REQ-024 SHALL give trap_flush priority over push and pop: pointers and count go to 0 next cycle, all same-cycle pushes are dropped, and overflow_err is unchanged.
REQ-025 SHALL hold overflow_err at 1 until rst.
REQ-026 SHALL give a pushed uop 1-cycle latency: it is visible on alu_uop at the cycle after acceptance, if it is the head.
REQ-027 SHALL leave entry storage unreset; only pointers, count and overflow_err are reset.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0 and overflow_err=0, overriding push, pop and trap_flush.
REQ-029 SHALL after reset drive alu_uop_valid=0, fifo_empty=1, fifo_full=0, fifo_almost_full=0 and overflow_err=0.
REQ-030 SHALL, when rst is asserted mid-operation with entries held, show empty on the following cycle; prior contents are never re-presented.

Verification
REQ-031 SHALL cover, at DEPTH=8, dual push A,B into an empty buffer -> next cycle alu_uop_valid=1 and alu_uop=A; pop -> alu_uop=B; pop -> fifo_empty=1.
REQ-032 SHALL cover filling to count=7, then push0+push1 -> both dropped, count stays 7, overflow_err=1; then a single push -> count=8 and fifo_full=1.
REQ-033 SHALL cover count=8 with pop_rs=1 and push0=1 -> push rejected, count=7, overflow_err=1.
REQ-034 SHALL cover wrap: pushing 20 uops with interleaved pops at DEPTH=5 -> pops return all 20 in push order, and the pointers pass 4->0.
REQ-035 SHALL cover count=5 with trap_flush=1, push0=1 and pop_rs=1 together -> next cycle count=0, alu_uop_valid=0, overflow_err unchanged.
REQ-036 SHALL cover rst=1 asserted at count=3 with push active -> next cycle fifo_empty=1, overflow_err=0, alu_uop_valid=0.
